pixel_fetch_engine: RTL and testbench

PIXEL_FETCH_ENGINE -- requirements
Module: pixel_fetch_engine

---
 rtl/pixel_fetch_engine.sv | 169 ++++++++++++++++
 tb/tb_pixel_fetch_engine.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/pixel_fetch_engine.sv
`timescale 1ns/1ps
// pixel_fetch_engine: fetches one pixel column from every subpanel
// through a fixed-latency RAM and publishes the full set atomically.
module pixel_fetch_engine #(
  parameter int SUBPANELS      = 2,
  parameter int ROW_BITS       = 4,
  parameter int COL_BITS       = 6,
  parameter int PIXEL_WIDTH    = 16,
  parameter int RAM_LATENCY    = 2,
  parameter int MIRROR_COLUMNS = 1,
  localparam int SB = (SUBPANELS > 1) ? $clog2(SUBPANELS) : 1,
  localparam int AW = SB + ROW_BITS + COL_BITS
) (
  input  logic                             i_clk,
  input  logic                             i_reset,
  input  logic [COL_BITS-1:0]              i_column_address,
  input  logic [ROW_BITS-1:0]              i_row_address,
  input  logic                             i_start,
  input  logic [PIXEL_WIDTH-1:0]           i_ram_data_in,
  output logic [AW-1:0]                    o_ram_address,
  output logic                             o_ram_clk_enable,
  output logic                             o_ram_reset,
  output logic                             o_busy,
  output logic                             o_done,
  output logic [SUBPANELS*PIXEL_WIDTH-1:0] o_pixels_out
);

  localparam int WB = $clog2(RAM_LATENCY + 1);
  localparam int PW = SUBPANELS * PIXEL_WIDTH;
  localparam logic [SB-1:0] K_LAST = SB'(SUBPANELS - 1);
  localparam logic [WB-1:0] W_LAST = WB'(RAM_LATENCY);

  typedef enum logic [1:0] {
    S_IDLE,
    S_FETCH,
    S_DONE
  } state_t;

  state_t                 r_state;
  state_t                 w_next_state;
  logic [SB-1:0]          r_k;
  logic [WB-1:0]          r_w;
  logic [ROW_BITS-1:0]    r_row;
  logic [COL_BITS-1:0]    r_col;
  logic [AW-1:0]          r_addr;
  logic [PIXEL_WIDTH-1:0] r_shadow [SUBPANELS];
  logic [PW-1:0]          r_pixels;
  logic [PW-1:0]          w_pixels;

  logic                   w_accept;
  logic                   w_capture;
  logic                   w_last_k;
  logic [SB-1:0]          w_k_inc;
  logic [COL_BITS-1:0]    w_in_col;
  logic [COL_BITS-1:0]    w_lat_col;

  assign w_accept  = (r_state == S_IDLE) && i_start;
  assign w_capture = (r_state == S_FETCH) && (r_w == W_LAST);
  assign w_last_k  = (r_k == K_LAST);
  assign w_k_inc   = r_k + 1'b1;

  // Panel scan order may run right-to-left; fold that into the column field.
  assign w_in_col  = (MIRROR_COLUMNS != 0) ? ~i_column_address : i_column_address;
  assign w_lat_col = (MIRROR_COLUMNS != 0) ? ~r_col : r_col;

  // State register.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic: one pass over all subpanels, then a single done cycle.
  always_comb begin
    w_next_state = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (i_start) begin
          w_next_state = S_FETCH;
        end
      end
      S_FETCH: begin
        if (w_capture && w_last_k) begin
          w_next_state = S_DONE;
        end
      end
      S_DONE: begin
        w_next_state = S_IDLE;
      end
      default: begin
        w_next_state = S_IDLE;
      end
    endcase
  end

  // Subpanel index and RAM wait counters.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_k <= '0;
      r_w <= '0;
    end else if (w_accept) begin
      r_k <= '0;
      r_w <= '0;
    end else if (w_capture) begin
      r_w <= '0;
      r_k <= w_last_k ? '0 : w_k_inc;
    end else if (r_state == S_FETCH) begin
      r_w <= r_w + 1'b1;
    end
  end

  // Request latch and RAM address; address moves only on start or capture.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_row  <= '0;
      r_col  <= '0;
      r_addr <= '0;
    end else if (w_accept) begin
      r_row  <= i_row_address;
      r_col  <= i_column_address;
      r_addr <= {SB'(0), i_row_address, w_in_col};
    end else if (w_capture && !w_last_k) begin
      r_addr <= {w_k_inc, r_row, w_lat_col};
    end
  end

  // Shadow slots collect words until the whole column is in hand.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      for (int i = 0; i < SUBPANELS; i++) begin
        r_shadow[i] <= '0;
      end
    end else begin
      for (int i = 0; i < SUBPANELS; i++) begin
        if (w_capture && (r_k == SB'(i))) begin
          r_shadow[i] <= i_ram_data_in;
        end
      end
    end
  end

  // Completed set: shadow slots, with the word arriving this edge bypassed in.
  always_comb begin
    w_pixels = '0;
    for (int i = 0; i < SUBPANELS; i++) begin
      w_pixels[i*PIXEL_WIDTH +: PIXEL_WIDTH] =
        (r_k == SB'(i)) ? i_ram_data_in : r_shadow[i];
    end
  end

  // Published pixels change only on the final capture edge.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_pixels <= '0;
    end else if (w_capture && w_last_k) begin
      r_pixels <= w_pixels;
    end
  end

  assign o_ram_address    = r_addr;
  assign o_busy           = (r_state == S_FETCH);
  assign o_done           = (r_state == S_DONE);
  assign o_ram_clk_enable = o_busy;
  assign o_ram_reset      = i_reset;
  assign o_pixels_out     = r_pixels;

endmodule

// File: tb/tb_pixel_fetch_engine.sv
`timescale 1ns/1ps
// tb_pixel_fetch_engine: directed stimulus with a queued scoreboard
// for a default instance and a 3-subpanel, latency-1 instance.
module tb_pixel_fetch_engine;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0;
  int n_fail = 0;

  typedef struct {
    logic [47:0] pix;
    int          cyc;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];

  // Instance A: defaults
  logic [5:0]  a_col, a_row_w;
  logic [3:0]  a_row;
  logic        a_start;
  logic [15:0] a_rdata;
  logic [10:0] a_addr;
  logic        a_ce, a_rrst, a_busy, a_done;
  logic [31:0] a_pix;

  pixel_fetch_engine u_a (
    .i_clk            (clk),
    .i_reset          (rst),
    .i_column_address (a_col),
    .i_row_address    (a_row),
    .i_start          (a_start),
    .i_ram_data_in    (a_rdata),
    .o_ram_address    (a_addr),
    .o_ram_clk_enable (a_ce),
    .o_ram_reset      (a_rrst),
    .o_busy           (a_busy),
    .o_done           (a_done),
    .o_pixels_out     (a_pix)
  );

  // Instance B: 3 subpanels, latency 1, straight columns
  logic [5:0]  b_col;
  logic [3:0]  b_row;
  logic        b_start;
  logic [15:0] b_rdata;
  logic [11:0] b_addr;
  logic        b_ce, b_rrst, b_busy, b_done;
  logic [47:0] b_pix;

  pixel_fetch_engine #(
    .SUBPANELS      (3),
    .RAM_LATENCY    (1),
    .MIRROR_COLUMNS (0)
  ) u_b (
    .i_clk            (clk),
    .i_reset          (rst),
    .i_column_address (b_col),
    .i_row_address    (b_row),
    .i_start          (b_start),
    .i_ram_data_in    (b_rdata),
    .o_ram_address    (b_addr),
    .o_ram_clk_enable (b_ce),
    .o_ram_reset      (b_rrst),
    .o_busy           (b_busy),
    .o_done           (b_done),
    .o_pixels_out     (b_pix)
  );

  // RAM models: word = address ^ 0x5000
  logic [10:0] a_p0, a_p1;
  logic [11:0] b_p0;
  always @(posedge clk) begin
    a_p0 <= a_addr;
    a_p1 <= a_p0;
    b_p0 <= b_addr;
  end
  assign a_rdata = 16'(a_p1) ^ 16'h5000;
  assign b_rdata = 16'(b_p0) ^ 16'h5000;
  assign a_row_w = '0;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Scoreboard monitor
  logic [31:0] a_prev = '0;
  logic [47:0] b_prev = '0;
  always @(negedge clk) begin : mon
    exp_t e;
    if (!rst) begin
      if (a_done) begin
        if (qa.size() == 0) begin
          chk("a_unexpected_done", 64'(a_done), 64'd0);
        end else begin
          e = qa.pop_front();
          chk("a_pixels", 64'(a_pix), 64'(e.pix));
          chk("a_done_cycle", 64'(cyc), 64'(e.cyc));
          chk("a_busy_in_done", 64'(a_busy), 64'd0);
        end
      end else if (a_pix !== a_prev) begin
        chk("a_pix_hold", 64'(a_pix), 64'(a_prev));
      end
      if (b_done) begin
        if (qb.size() == 0) begin
          chk("b_unexpected_done", 64'(b_done), 64'd0);
        end else begin
          e = qb.pop_front();
          chk("b_pixels", 64'(b_pix), 64'(e.pix));
          chk("b_done_cycle", 64'(cyc), 64'(e.cyc));
        end
      end else if (b_pix !== b_prev) begin
        chk("b_pix_hold", 64'(b_pix), 64'(b_prev));
      end
      if (b_busy) begin
        chk("b_sub_range", 64'(b_addr[11:10] != 2'd3), 64'd1);
      end
    end
    a_prev = a_pix;
    b_prev = b_pix;
  end

  task automatic issue_a(input logic [5:0] c, input logic [3:0] r,
                         input logic hold, output int e0);
    a_col = c;
    a_row = r;
    a_start = 1'b1;
    @(posedge clk);
    #1;
    e0 = cyc;
    a_start = hold;
  endtask

  task automatic push_a(input logic [31:0] p, input int c);
    exp_t e;
    e.pix = 48'(p);
    e.cyc = c;
    qa.push_back(e);
  endtask

  task automatic drain(input int bound);
    int n = 0;
    while ((qa.size() != 0 || qb.size() != 0) && n < bound) begin
      @(negedge clk);
      n++;
    end
    chk("drain_timeout", 64'(qa.size() + qb.size()), 64'd0);
    @(negedge clk);
  endtask

  initial begin
    int e0;
    exp_t eb;
    rst = 1'b1;
    a_start = 1'b0; a_col = '0; a_row = '0;
    b_start = 1'b0; b_col = '0; b_row = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy", 64'(a_busy), 64'd0);
    chk("rst_done", 64'(a_done), 64'd0);
    chk("rst_addr", 64'(a_addr), 64'd0);
    chk("rst_pix", 64'(a_pix), 64'd0);
    chk("rst_ce", 64'(a_ce), 64'd0);
    chk("rst_ram_reset", 64'(a_rrst), 64'd1);
    chk("rst_b_pix", 64'(b_pix), 64'd0);
    chk("rst_b_ram_reset", 64'(b_rrst), 64'd1);

    // Basic fetch, start on first edge after reset release
    @(negedge clk);
    rst = 1'b0;
    issue_a(6'h05, 4'h3, 1'b0, e0);
    push_a(32'h54FA_50FA, e0 + 6);
    chk("t1_ram_reset_low", 64'(a_rrst), 64'd0);
    chk("t1_addr0", 64'(a_addr), 64'h0FA);
    chk("t1_busy", 64'(a_busy), 64'd1);
    chk("t1_ce", 64'(a_ce), 64'd1);
    repeat (2) @(posedge clk);
    #1 chk("t1_addr0_hold", 64'(a_addr), 64'h0FA);
    @(posedge clk);
    #1 chk("t1_addr1", 64'(a_addr), 64'h4FA);
    drain(30);

    // Input churn and start pulses during a fetch
    @(negedge clk);
    issue_a(6'h05, 4'h3, 1'b0, e0);
    push_a(32'h54FA_50FA, e0 + 6);
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      a_col = 6'(k * 11);
      a_row = 4'(k * 5);
      a_start = k[0];
      @(posedge clk);
      #1 chk("t2_addr", 64'(a_addr), (k < 3) ? 64'h0FA : 64'h4FA);
    end
    @(negedge clk);
    a_start = 1'b0;
    drain(30);
    repeat (4) @(negedge clk);
    chk("t2_no_refetch", 64'(a_busy), 64'd0);

    // Reset mid-fetch, with start held through reset
    @(negedge clk);
    issue_a(6'h2A, 4'h9, 1'b0, e0);
    repeat (4) @(posedge clk);
    #2;
    rst = 1'b1;
    a_start = 1'b1;
    #1;
    chk("t3_busy", 64'(a_busy), 64'd0);
    chk("t3_done", 64'(a_done), 64'd0);
    chk("t3_pix", 64'(a_pix), 64'd0);
    chk("t3_addr", 64'(a_addr), 64'd0);
    repeat (3) @(posedge clk);
    #1 chk("t3_start_in_reset", 64'(a_busy), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    issue_a(6'h3F, 4'hF, 1'b0, e0);
    push_a(32'h57C0_53C0, e0 + 6);
    chk("t3_addr_restart", 64'(a_addr), 64'h3C0);
    drain(30);

    // Start held high: three fetches, DONE cycle swallows start
    @(negedge clk);
    issue_a(6'h10, 4'h7, 1'b1, e0);
    a_col = 6'h11;
    push_a(32'h55EF_51EF, e0 + 6);
    push_a(32'h55EE_51EE, e0 + 14);
    push_a(32'h55ED_51ED, e0 + 22);
    repeat (8) @(posedge clk);
    #1 a_col = 6'h12;
    repeat (15) @(posedge clk);
    #1 a_start = 1'b0;
    drain(40);
    repeat (3) @(negedge clk);
    chk("t4_idle_after", 64'(a_busy), 64'd0);

    // Three subpanels, latency 1, no mirroring
    @(negedge clk);
    b_col = 6'h05;
    b_row = 4'h3;
    b_start = 1'b1;
    @(posedge clk);
    #1;
    e0 = cyc;
    b_start = 1'b0;
    eb.pix = 48'h58C5_54C5_50C5;
    eb.cyc = e0 + 6;
    qb.push_back(eb);
    chk("b_addr0", 64'(b_addr), 64'h0C5);
    chk("b_ce", 64'(b_ce), 64'd1);
    repeat (2) @(posedge clk);
    #1 chk("b_addr1", 64'(b_addr), 64'h4C5);
    repeat (2) @(posedge clk);
    #1 chk("b_addr2", 64'(b_addr), 64'h8C5);
    drain(30);

    repeat (3) @(negedge clk);
    chk("final_queues", 64'(qa.size() + qb.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
